// File: rtl/sram_ctrl.sv
// Registered controller for one asynchronous SRAM: valid/ready request port,
// multi-cycle read/write sequencing with configurable wait states and split pad data.
module sram_ctrl #(
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int ADDR_W   = 20,
    parameter int ADDR_LSB = 2,
    parameter int RD_WAIT  = 2,
    parameter int WR_WAIT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [BE_W-1:0]   sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_data_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BE_W-1:0]   ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [7:0] RD_LOAD = 8'(RD_WAIT - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_WAIT - 1);

    state_t     state;
    logic [7:0] cnt;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_LSB+ADDR_W], addr_i[ADDR_LSB-1:0]};

    assign ready_o = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_be_n    <= '1;
            ram_addr    <= '0;
            ram_data_o  <= '0;
            ram_data_oe <= 1'b0;
            ack_o       <= 1'b0;
            data_o      <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        ram_addr <= addr_i[ADDR_LSB+ADDR_W-1:ADDR_LSB];
                        ram_ce_n <= 1'b0;
                        if (we_i) begin
                            state       <= WR_SETUP;
                            ram_be_n    <= ~sel_i;
                            ram_data_o  <= data_i;
                            ram_data_oe <= 1'b1;
                            cnt         <= 8'd0;
                        end else begin
                            state    <= READ;
                            ram_oe_n <= 1'b0;
                            ram_be_n <= '0;
                            cnt      <= RD_LOAD;
                        end
                    end
                end
                READ: begin
                    if (cnt == 8'd0) begin
                        state    <= IDLE;
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_be_n <= '1;
                        data_o   <= ram_data_i;
                        ack_o    <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WR_SETUP: begin
                    state    <= WR_PULSE;
                    ram_we_n <= 1'b0;
                    cnt      <= WR_LOAD;
                end
                WR_PULSE: begin
                    if (cnt == 8'd0) begin
                        state    <= WR_HOLD;
                        ram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                // Dropping data_oe here leaves the ack cycle as the turnaround gap.
                WR_HOLD: begin
                    state       <= IDLE;
                    ram_ce_n    <= 1'b1;
                    ram_data_oe <= 1'b0;
                    ram_be_n    <= '1;
                    ack_o       <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with default parameters
// (32-bit data, 20-bit word address, RD_WAIT = 2, WR_WAIT = 1).
module tb_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] data_o;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        ram_data_oe;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    int errors = 0;
    int checks = 0;

    sram_ctrl dut (
        .clk(clk),
        .rst(rst),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .sel_i(sel_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .ack_o(ack_o),
        .data_o(data_o),
        .ram_data_i(ram_data_i),
        .ram_data_o(ram_data_o),
        .ram_data_oe(ram_data_oe),
        .ram_addr(ram_addr),
        .ram_be_n(ram_be_n),
        .ram_ce_n(ram_ce_n),
        .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge: sample and drive point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
        req_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        sel_i  = sel;
        data_i = data;
    endtask

    task automatic test_reset();
        // Start a read so that outputs are away from their reset values.
        issue(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        ram_data_i = 32'hCAFE_F00D;
        tick();
        req_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n} !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got ce/oe/we/be=%b required 1111111",
                     {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n});
        end
        checks++;
        if (ram_addr !== 20'h0 || ram_data_o !== 32'h0 || ram_data_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pad: got addr=%h dout=%h oe=%b required 0 0 0",
                     ram_addr, ram_data_o, ram_data_oe);
        end
        checks++;
        if (ack_o !== 1'b0 || data_o !== 32'h0 || ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got ack=%b data_o=%h ready=%b required 0 0 0",
                     ack_o, data_o, ready_o);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b required 1", ready_o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (ack_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_ack: got ack=%b required 0 (cycle %0d)", ack_o, c);
            end
        end
    endtask

    task automatic test_read();
        ram_data_i = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        tick();
        req_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            logic exp_oe_n;
            logic exp_ack;
            exp_oe_n = (c <= 2) ? 1'b0 : 1'b1;
            exp_ack  = (c == 3);
            checks++;
            if (ram_oe_n !== exp_oe_n || ack_o !== exp_ack) begin
                errors++;
                $display("[TB] FAIL read_timing: cycle %0d got oe_n=%b ack=%b required oe_n=%b ack=%b",
                         c, ram_oe_n, ack_o, exp_oe_n, exp_ack);
            end
            if (c == 1) begin
                checks++;
                if (ram_addr !== 20'h00004 || ram_be_n !== 4'b0000 || ram_ce_n !== 1'b0
                    || ram_data_oe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL read_setup: got addr=%h be_n=%b ce_n=%b doe=%b required 00004 0000 0 0",
                             ram_addr, ram_be_n, ram_ce_n, ram_data_oe);
                end
            end
            if (c == 3) begin
                checks++;
                if (data_o !== 32'hDEAD_BEEF || ready_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL read_data: got data_o=%h ready=%b required deadbeef 1",
                             data_o, ready_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_write();
        issue(1'b1, 32'h0000_0008, 4'b0011, 32'h1234_5678);
        tick();
        req_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            logic exp_we_n;
            logic exp_doe;
            logic exp_ack;
            exp_we_n = (c == 2) ? 1'b0 : 1'b1;
            exp_doe  = (c <= 3);
            exp_ack  = (c == 4);
            checks++;
            if (ram_we_n !== exp_we_n || ram_data_oe !== exp_doe || ack_o !== exp_ack) begin
                errors++;
                $display("[TB] FAIL write_timing: cycle %0d got we_n=%b doe=%b ack=%b required %b %b %b",
                         c, ram_we_n, ram_data_oe, ack_o, exp_we_n, exp_doe, exp_ack);
            end
            if (c <= 3) begin
                checks++;
                if (ram_addr !== 20'h00002 || ram_be_n !== 4'b1100 || ram_data_o !== 32'h1234_5678
                    || ram_ce_n !== 1'b0 || ram_oe_n !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL write_bus: cycle %0d got addr=%h be_n=%b dout=%h ce_n=%b oe_n=%b required 00002 1100 12345678 0 1",
                             c, ram_addr, ram_be_n, ram_data_o, ram_ce_n, ram_oe_n);
                end
            end
            if (c == 4) begin
                checks++;
                if (data_o !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("[TB] FAIL write_data_o: got %h required deadbeef", data_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        ram_data_i = 32'h0BAD_F00D;
        issue(1'b1, 32'h0000_0020, 4'hF, 32'hAAAA_5555);
        tick();
        // Next request is a read; req stays high until it is taken.
        issue(1'b0, 32'h0000_0040, 4'hF, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (ram_data_oe === 1'b1 && ram_oe_n === 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_contention: cycle %0d got doe=%b oe_n=%b required not both active",
                         c, ram_data_oe, ram_oe_n);
            end
            if (c == 4) begin
                checks++;
                if (ack_o !== 1'b1 || ready_o !== 1'b1 || ram_data_oe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_wr_ack: got ack=%b ready=%b doe=%b required 1 1 0",
                             ack_o, ready_o, ram_data_oe);
                end
            end
            if (c == 5) begin
                req_i = 1'b0;
                checks++;
                if (ram_oe_n !== 1'b0 || ram_addr !== 20'h00010 || ack_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_rd_start: got oe_n=%b addr=%h ack=%b required 0 00010 0",
                             ram_oe_n, ram_addr, ack_o);
                end
            end
            if (c == 7) begin
                checks++;
                if (ack_o !== 1'b1 || data_o !== 32'h0BAD_F00D) begin
                    errors++;
                    $display("[TB] FAIL b2b_rd_ack: got ack=%b data_o=%h required 1 0badf00d",
                             ack_o, data_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_wr_pulse();
        issue(1'b1, 32'h0000_0004, 4'hF, 32'h5555_AAAA);
        tick();
        req_i = 1'b0;
        tick();
        checks++;
        if (ram_we_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pulse: got we_n=%b required 0", ram_we_n);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ram_we_n !== 1'b1 || ram_ce_n !== 1'b1 || ram_data_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_async: got we_n=%b ce_n=%b doe=%b required 1 1 0",
                     ram_we_n, ram_ce_n, ram_data_oe);
        end
        tick();
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (ack_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_no_ack: got ack=%b required 0 (cycle %0d)", ack_o, c);
            end
        end
        ram_data_i = 32'h1357_9BDF;
        issue(1'b0, 32'h0000_0000, 4'hF, 32'h0);
        tick();
        req_i = 1'b0;
        tick();
        tick();
        checks++;
        if (ack_o !== 1'b1 || data_o !== 32'h1357_9BDF) begin
            errors++;
            $display("[TB] FAIL abort_recover: got ack=%b data_o=%h required 1 13579bdf",
                     ack_o, data_o);
        end
        tick();
    endtask

    task automatic test_sel_zero();
        issue(1'b1, 32'h0000_0030, 4'b0000, 32'hFFFF_FFFF);
        tick();
        req_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            logic exp_ack;
            exp_ack = (c == 4);
            checks++;
            if (ram_be_n !== 4'b1111 || ack_o !== exp_ack) begin
                errors++;
                $display("[TB] FAIL sel0: cycle %0d got be_n=%b ack=%b required 1111 %b",
                         c, ram_be_n, ack_o, exp_ack);
            end
            if (c == 2) begin
                checks++;
                if (ram_we_n !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sel0_pulse: got we_n=%b required 0", ram_we_n);
                end
            end
            tick();
        end
        checks++;
        if (data_o !== 32'h1357_9BDF) begin
            errors++;
            $display("[TB] FAIL sel0_data_o: got %h required 13579bdf", data_o);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_i      = 1'b0;
        we_i       = 1'b0;
        addr_i     = 32'h0;
        sel_i      = 4'h0;
        data_i     = 32'h0;
        ram_data_i = 32'h0;
        #12;
        rst = 1'b0;
        tick();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_wr_pulse();
        test_sel_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
